// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator for a big-endian, word-wide data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module dmem_lsu #(
  parameter int RD_WAIT   = 2,
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_writeenable,
  output logic        mem_read,
  input  logic [31:0] mem_data,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; once raised, valid and its payload hold until that edge.
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int          CW       = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [1:0]    r_off;
  logic [31:0]   r_wdata;
  logic [31:0]   aligned;
  logic          req_err;

  assign dbg_state = state;
  assign aligned   = {req_addr[31:2], 2'b00};
  assign req_err   = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     (aligned > MAX_ADDR);

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                        input logic [1:0] size, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) begin
      case (off)
        2'd0:    m[31:24] = d[7:0];
        2'd1:    m[23:16] = d[7:0];
        2'd2:    m[15:8]  = d[7:0];
        default: m[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      m[15:0] = d[15:0];
    end else begin
      m[31:16] = d[15:0];
    end
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      req_ready       <= 1'b0;
      resp_valid      <= 1'b0;
      resp_err        <= 1'b0;
      resp_rdata      <= '0;
      mem_address     <= '0;
      mem_writedata   <= '0;
      mem_writeenable <= 1'b0;
      mem_read        <= 1'b0;
      r_write         <= 1'b0;
      r_size          <= '0;
      r_signed        <= 1'b0;
      r_off           <= '0;
      r_wdata         <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_off     <= req_addr[1:0];
            r_wdata   <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_size == 2'b10) begin
              state           <= WRITE;
              mem_address     <= aligned;
              mem_writedata   <= req_wdata;
              mem_writeenable <= 1'b1;
            end else begin
              state       <= READ;
              mem_address <= aligned;
              mem_read    <= 1'b1;
              cnt         <= CW'(1);
            end
          end
        end
        READ: begin
          if (cnt == CW'(RD_WAIT)) begin
            mem_read <= 1'b0;
            cnt      <= '0;
            if (r_write) begin
              state           <= WRITE;
              mem_writedata   <= merge(mem_data, r_off, r_size, r_wdata);
              mem_writeenable <= 1'b1;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= extract(mem_data, r_off, r_size, r_signed);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WRITE: begin
          mem_writeenable <= 1'b0;
          state           <= RESP;
          resp_valid      <= 1'b1;
          resp_rdata      <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus randomized traffic checked against a
// word-array reference memory with arithmetic lane extraction and merging.
module tb_dmem_lsu;

  localparam int RD_WAIT   = 2;
  localparam int MEM_BYTES = 1024;
  localparam int NW        = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;
  logic        mem_read;
  logic [31:0] mem_data = '0;
  logic [1:0]  dbg_state;

  logic [31:0] dmem[NW];
  logic [31:0] ref_mem[NW];
  logic        preload = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  dmem_lsu #(.RD_WAIT(RD_WAIT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_writeenable(mem_writeenable), .mem_read(mem_read), .mem_data(mem_data),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // Memory with a one-cycle registered read buffer.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NW; i++) dmem[i] <= ref_mem[i];
    end else if (mem_writeenable) begin
      dmem[mem_address[9:2]] <= mem_writedata;
    end
    mem_data <= dmem[mem_address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: what a request should produce, from the lane rules.
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat,
                       output logic [31:0] nw);
    int          off;
    int          sh;
    logic [31:0] w;
    logic [31:0] mask;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
          ((a & ~32'd3) > 32'(MEM_BYTES - 4));
    rd  = '0;
    nw  = '0;
    lat = 1;
    if (err) return;
    off = int'(a[1:0]);
    w   = ref_mem[int'(a >> 2)];
    if (!wr) begin
      lat = RD_WAIT + 1;
      if (sz == 2'd0) begin
        rd = (w >> (24 - 8 * off)) & 32'hFF;
        if (sg && rd >= 32'd128) rd = rd - 32'd256;
      end else if (sz == 2'd1) begin
        rd = (w >> (16 - 8 * off)) & 32'hFFFF;
        if (sg && rd >= 32'd32768) rd = rd - 32'd65536;
      end else begin
        rd = w;
      end
    end else if (sz == 2'd2) begin
      lat = 2;
      nw  = wd;
    end else begin
      lat  = RD_WAIT + 2;
      sh   = (sz == 2'd0) ? 24 - 8 * off : 16 - 8 * off;
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      nw   = (w & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Driver + scoreboard for one request; starts and ends at a falling edge.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd, exp_nw, exp_data, got_addr, got_wd;
    logic        exp_err;
    int          exp_lat, n, lat, we_cnt, rd_cnt, both, bad_raddr;
    model(wr, sz, sg, a, wd, exp_rd, exp_err, exp_lat, exp_nw);
    exp_q.push_back(exp_rd);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = $urandom_range(0, 1);
    req_size  = 2'($urandom_range(0, 3));
    lat = 0; we_cnt = 0; rd_cnt = 0; both = 0; bad_raddr = 0;
    got_addr = '0; got_wd = '0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (mem_read && mem_writeenable) both++;
      if (mem_read) begin
        rd_cnt++;
        if (mem_address !== (a & ~32'd3)) bad_raddr++;
      end
      if (mem_writeenable) begin
        we_cnt++;
        got_addr = mem_address;
        got_wd   = mem_writedata;
      end
      if (resp_valid) break;
    end
    exp_data = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("resp_rdata", resp_rdata, exp_data);
    chk("we_cycles", 32'(we_cnt), (wr && !exp_err) ? 32'd1 : 32'd0);
    chk("rd_cycles", 32'(rd_cnt), (exp_err || (wr && sz == 2'd2)) ? 32'd0 : 32'(RD_WAIT));
    chk("rd_we_overlap", 32'(both), 32'd0);
    chk("rd_address", 32'(bad_raddr), 32'd0);
    if (wr && !exp_err) begin
      chk("wr_address", got_addr, a & ~32'd3);
      chk("wr_data", got_wd, exp_nw);
      ref_mem[int'(a >> 2)] = exp_nw;
    end
    last_rdata = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_data);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;
    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h812233F4;
    ref_mem[8] = 32'h11223344;

    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_out", {mem_address[30:0], mem_writeenable}, 32'd0);
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(req_ready), 32'd1);

    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0);
    chk("tp_lb_signed", last_rdata, 32'hFFFFFFF4);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0);
    chk("tp_lb_unsigned", last_rdata, 32'h00000081);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 0);
    chk("tp_lh_signed", last_rdata, 32'hFFFF8122);
    do_req(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 0);
    chk("tp_lw", last_rdata, 32'h812233F4);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hAAAABEEF, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    chk("tp_lw_after_sh", last_rdata, 32'h8122BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h12345678, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);

    for (int k = 0; k < 80; k++) begin
      sz = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
      case ($urandom_range(0, 9))
        0:       a = 32'(MEM_BYTES) + $urandom_range(0, 15);
        1:       a = 32'hFFFFFFFC;
        default: a = $urandom_range(0, MEM_BYTES - 1);
      endcase
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3));
    end

    // Reset while a byte store is in its write cycle.
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!mem_writeenable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached_write", 32'(mem_writeenable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_writeenable), 32'd0);
    chk("rst_mid_rd", 32'(mem_read), 32'd0);
    chk("rst_mid_addr", mem_address, 32'd0);
    chk("rst_mid_wdata", mem_writedata, 32'd0);
    chk("rst_mid_resp", {resp_rdata[29:0], resp_valid, resp_err}, 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_mem", dmem[8], ref_mem[8]);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_ready_hold", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid_ready_up", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);

    n = 0;
    for (int i = 0; i < NW; i++) if (dmem[i] !== ref_mem[i]) n++;
    chk("mem_final", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
